logic_sweep_checker: RTL

//   Self-contained hardware sweeper/checker for an N_IN-input, 1-output combinational block.

---
 rtl/logic_sweep_checker.sv | 118 +++++++++++
 1 files changed

// File: rtl/logic_sweep_checker.sv
// Exhaustive sweeper/checker for an N_IN-input, 1-output combinational block.
// Optional build macro SWEEP_GRAY_EN: drive x in Gray-code order instead of binary.
module logic_sweep_checker #(
    parameter int N_IN   = 3,
    parameter int HOLD   = 10,
    parameter int SETTLE = 1,
    localparam int T     = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [T-1:0]    expected,
    input  logic            y,
    output logic [N_IN-1:0] x,
    output logic            busy,
    output logic            done,
    output logic [T-1:0]    truth,
    output logic [T-1:0]    mismatch,
    output logic [N_IN:0]   err_cnt,
    output logic            pass
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] SAMPLE_AT = HW'(SETTLE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [T-1:0]    exp_q;
    logic [N_IN-1:0] vec_idx;
    logic [HW-1:0]   hold_cnt;
    logic [N_IN-1:0] vec_x;
    logic            last_tick;

`ifdef SWEEP_GRAY_EN
    assign vec_x = vec_idx ^ (vec_idx >> 1);
`else
    assign vec_x = vec_idx;
`endif

    assign last_tick = (hold_cnt == HOLD_LAST) && (vec_idx == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_tick) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
        x    = (state == RUN) ? vec_x : '0;
    end

    // Results are indexed by the value on x, so Gray order needs no remapping here.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q    <= '0;
            truth    <= '0;
            mismatch <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            vec_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q    <= expected;
                        truth    <= '0;
                        mismatch <= '0;
                        err_cnt  <= '0;
                        pass     <= 1'b0;
                        vec_idx  <= '0;
                        hold_cnt <= '0;
                    end
                end
                RUN: begin
                    if (hold_cnt == SAMPLE_AT) begin
                        truth[x]    <= y;
                        mismatch[x] <= y ^ exp_q[x];
                        if (y ^ exp_q[x]) err_cnt <= err_cnt + 1'b1;
                    end
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (vec_idx != '1) vec_idx <= vec_idx + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                FIN: begin
                    pass    <= (err_cnt == '0);
                    vec_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
